// File: rtl/btn_debounce.sv
// Button/switch debouncer: captures a raw level, qualifies it for STABLE_CNT cycles, then emits
// a clean level plus one-cycle rise/fall strobes. Define BTN_DEBOUNCE_SYNC_EN for a 2-flop sync.
module btn_debounce #(
    parameter int unsigned STABLE_CNT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    typedef enum logic {
        StStableLo = 1'b0,
        StStableHi = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s_q;

`ifdef BTN_DEBOUNCE_SYNC_EN
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            sync_q <= in;
            s_q    <= sync_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= 1'b0;
        end else begin
            s_q <= in;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStableLo: begin
                if (!s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StStableHi;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStableHi: begin
                if (s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StStableLo;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out  = (state_q == StStableHi);
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CNT=4, CNT_W=3; latency follows BTN_DEBOUNCE_SYNC_EN.
module tb_btn_debounce;

`ifdef BTN_DEBOUNCE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int N = L + 4;

    logic clk;
    logic reset;
    logic in;
    logic out;
    logic rise;
    logic fall;

    int tests;
    int fails;

    btn_debounce #(
        .STABLE_CNT(4),
        .CNT_W     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .out  (out),
        .rise (rise),
        .fall (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; observe and drive #1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp);
        tests++;
        assert ({out, rise, fall} === exp)
        else begin
            fails++;
            $error("FAIL %s: {out,rise,fall} observed=%b expected=%b", tag, {out, rise, fall}, exp);
        end
    endtask

    // n edges: quiet until the last, which shows exp_at; the following edge drops the strobe.
    task automatic wait_change(input string tag, input int n, input logic [2:0] exp_before,
                               input logic [2:0] exp_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk(tag, (k < n) ? exp_before : exp_at);
        end
        tick();
        chk({tag, "_strobe_end"}, {exp_at[2], 2'b00});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        in    = 1'b1;

        // Reset held 3 cycles with in high.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_hold", 3'b000);
        end
        reset = 1'b0;
        // Held-high input re-qualified from zero after release.
        wait_change("reset_requal", N, 3'b000, 3'b110);

        // Release to get back to 0.
        in = 1'b0;
        wait_change("release1", N, 3'b100, 3'b001);

        // Clean press held 20 cycles.
        in = 1'b1;
        wait_change("clean_press", N, 3'b000, 3'b110);
        for (int k = N + 1; k < 20; k++) begin
            tick();
            chk("press_hold", 3'b100);
        end

        in = 1'b0;
        wait_change("release2", N, 3'b100, 3'b001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("low_hold", 3'b000);
        end

        // Bounce 1,0,1,0 with 2-cycle phases, then hold 1.
        for (int p = 0; p < 4; p++) begin
            in = (p % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("bounce", 3'b000);
            end
        end
        in = 1'b1;
        wait_change("bounce_settle", N, 3'b000, 3'b110);

        in = 1'b0;
        wait_change("release3", N, 3'b100, 3'b001);

        // Glitch of STABLE_CNT-1 cycles must be ignored.
        in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("glitch_hi", 3'b000);
        end
        in = 1'b0;
        for (int k = 0; k < L + 6; k++) begin
            tick();
            chk("glitch_after", 3'b000);
        end

        // Mid-count reset discards partial qualification.
        in = 1'b1;
        tick();
        chk("midrst_pre", 3'b000);
        tick();
        chk("midrst_pre", 3'b000);
        reset = 1'b1;
        tick();
        chk("midrst_in_reset", 3'b000);
        reset = 1'b0;
        wait_change("midrst_requal", N, 3'b000, 3'b110);

        // Reset while high clears out.
        reset = 1'b1;
        tick();
        chk("reset_from_high", 3'b000);
        reset = 1'b0;
        in    = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("idle_after_reset", 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioning stage that sits directly upstream of the lab inverter. It takes a raw, asynchronous, possibly bouncing push-button or switch level and synchronises it to the system clock. It produces a clean, debounced level for the inverter's `in` port, plus single-cycle rise/fall strobes for later sequential labs.

## Interface

Parameters:
- `STABLE_CNT`, default 16. Number of consecutive clock cycles the synchronised input must differ from `out` before `out` follows it. Legal range is 1 to 2^`CNT_W`.
- `CNT_W`, default 5. Width of the stability counter.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in` input 1: raw button/switch level; asynchronous to `clk`; may bounce.
- `out` output 1: debounced level; drives the inverter stage's `in`.
- `rise` output 1: one-cycle pulse when `out` goes 0→1.
- `fall` output 1: one-cycle pulse when `out` goes 1→0.

## Operation

- Input capture produces the internal sampled level `s`. The capture path is fixed by `BTN_DEBOUNCE_SYNC_EN`; see Configuration.
- State machine has two states, encoded by the `out` register:
  - STABLE_LO (`out`=0)
  - STABLE_HI (`out`=1)
- Counter `cnt` (`CNT_W` bits) runs alongside the state:
  - `s == out`: `cnt` ← 0. Any glitch back to the current level restarts qualification.
  - `s != out` and `cnt < STABLE_CNT-1`: `cnt` ← `cnt`+1.
  - `s != out` and `cnt == STABLE_CNT-1`: `out` ← `s`, `cnt` ← 0. In the same edge, assert `rise` if `s`=1, else `fall`.
- `cnt` never exceeds `STABLE_CNT-1`. It does not wrap and does not saturate.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- `STABLE_CNT`=1: `out` follows `s` one edge after `s` changes. A pulse is emitted on every change.
- Reset (synchronous, wins over everything):
  - `out`=0, `rise`=0, `fall`=0, `cnt`=0, all capture flops=0.
  - Reset mid-qualification discards the partial count.
  - After release, a held-high `in` is re-qualified from zero and produces a `rise`.

## Timing

- All outputs are registered. There is no combinational path from `in` to any output.
- Capture latency L from `in` to `s`:
  - 2 edges with `BTN_DEBOUNCE_SYNC_EN`
  - 1 edge without it
- Change latency: `in` changes and is held. `out`, and the matching strobe, update exactly L + `STABLE_CNT` rising edges later.
- Strobe timing: `rise`/`fall` assert in the same cycle `out` first shows its new value. They deassert on the next edge.
- A bounce shorter than `STABLE_CNT` cycles, as seen at `s`, produces no change on `out`, `rise` or `fall`.
- Reset asserted in cycle t: all outputs read 0 after edge t.

## Configuration

- Macro: `BTN_DEBOUNCE_SYNC_EN`.
- Defined: `in` passes through a two-flop synchroniser before reaching `s` (L=2). This is the build for physical buttons on the board.
- Undefined: a single capture flop feeds `s` (L=1). This is for simulation or already-synchronous sources; metastability protection is absent.
- Counter and state-machine behaviour are identical in both builds. Only L differs.

## Test plan

Bench uses `STABLE_CNT`=4 and `CNT_W`=3; run with the macro defined (L=2) and undefined (L=1).

- Reset: hold `reset` 3 cycles with `in`=1 → `out`=0, `rise`=0, `fall`=0 during reset and on the first edge after it.
- Clean press: `in` 0→1 held 20 cycles → `out`=1 and `rise`=1 exactly L+4 edges after the change. `rise` lasts 1 cycle; `fall` stays 0.
- Bounce: `in` toggles 1,0,1,0 with 2-cycle phases, then holds 1 → no output activity during bouncing. `out` rises L+4 edges after the final 0→1.
- Release: from `out`=1, `in`→0 held → `out`=0 and `fall`=1 for one cycle after L+4 edges.
- Short glitch: from steady `out`=0, `in`=1 for 3 cycles, then 0 → `out`, `rise`, `fall` remain 0 throughout.
- Mid-count reset: `in`→1, pulse `reset` for 1 cycle 2 edges later, keep `in`=1 → `rise` occurs L+4 edges after reset release, not earlier.
